// File: rtl/hazard_unit.sv
// Pipeline hazard unit: freezes the pipeline on memory/fetch waits, flushes on
// redirects resolved in MEM, and inserts one bubble for load-use hazards.
// Also keeps saturating counters of stall cycles and flush events.
module hazard_unit (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        exmem_redirect,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        flush_IDEX,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DWAIT   = 2'd1,
        LUSTALL = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic mem_busy;
    logic freeze;
    logic loaduse;
    logic redirect_taken;

    assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign freeze   = mem_busy | ~ihit;
    // Register zero never carries a real dependency, so it cannot cause a stall.
    assign loaduse  = idex_memread & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

    // Priority decode of enables, flushes and next state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        ifid_flush     = 1'b0;
        flush_IDEX     = 1'b0;
        redirect_taken = 1'b0;
        state_next     = RUN;

        if (!nRST) begin
            // Outputs are gated directly by reset so they drop without a clock.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
        end else if (freeze) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            state_next = mem_busy ? DWAIT : state;
        end else if (exmem_redirect) begin
            // Redirect outranks load-use: the stalled instruction is being discarded anyway.
            ifid_flush     = 1'b1;
            flush_IDEX     = 1'b1;
            redirect_taken = 1'b1;
            state_next     = FLUSH;
        end else if (loaduse && (state == RUN || state == DWAIT)) begin
            // In LUSTALL/FLUSH the IF/ID instruction was already resolved, so detection is masked.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_IDEX = 1'b1;
            state_next = LUSTALL;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state <= state_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            if (!pc_en && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (redirect_taken && flush_events != 16'hFFFF) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end

endmodule
